truth_table_checker: RTL

Parametrised, self-checking truth-table engine for N-input logic gates: on `start` it drives every input combination 0 … 2^N−1 onto a gate under test and compares the sampled gate output against a selected reference function. It counts mismatches, reports the first failing vector, and raises `done`/`pass`. It is the synthesisable, generalised successor to our fixed 2-input gate benches, usable on-chip or as a reusable bench component.

---
 rtl/truth_table_checker.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/truth_table_checker.sv
// truth_table_checker: sweeps every N-bit input vector onto an external gate,
// compares the gate's response against a selectable reduction function, and
// reports the mismatch count and the first failing vector.
module truth_table_checker #(
    parameter int N      = 2,   // gate inputs, 1..8
    parameter int SETTLE = 0    // extra hold cycles before sampling, 0..15
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [2:0]   mode,
    input  logic         dut_out,
    output logic [N-1:0] dut_in,
    output logic         busy,
    output logic         done,
    output logic         pass,
    output logic [N:0]   err_count,
    output logic         first_err_valid,
    output logic [N-1:0] first_err_vec
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_CHECK,
        S_DONE
    } state_t;

    // Vector counter carries one spare bit so the last vector is detected
    // without relying on wrap-around.
    localparam logic [N:0] LAST_VEC = {1'b0, {N{1'b1}}};
    // err_count can reach 2^N (every vector wrong) and must never wrap.
    localparam logic [N:0] ERR_MAX  = {1'b1, {N{1'b0}}};
    // The settle counter is loaded with SETTLE-1 so SETTLE state lasts
    // exactly SETTLE cycles; with SETTLE=0 the state is skipped entirely.
    localparam logic [3:0] SETTLE_INIT = (SETTLE > 0) ? 4'(SETTLE - 1) : 4'd0;
    localparam state_t     VEC_STATE   = (SETTLE > 0) ? S_SETTLE : S_CHECK;

    state_t       state_q, state_d;
    logic [N:0]   vec_q, vec_d;
    logic [3:0]   settle_cnt_q, settle_cnt_d;
    logic [2:0]   mode_q, mode_d;
    logic [N:0]   err_q, err_d;
    logic         first_valid_q, first_valid_d;
    logic [N-1:0] first_vec_q, first_vec_d;
    logic         expected;

    // Reference value of the latched function for the current vector.
    always_comb begin
        // NOTE: every variable written here gets a value on every path
        // (default first), otherwise synthesis infers a latch.
        expected = 1'b0;
        case (mode_q)
            3'd0:    expected =  (&vec_q[N-1:0]);
            3'd1:    expected =  (|vec_q[N-1:0]);
            3'd2:    expected = ~(&vec_q[N-1:0]);
            3'd3:    expected = ~(|vec_q[N-1:0]);
            3'd4:    expected =  (^vec_q[N-1:0]);
            3'd5:    expected = ~(^vec_q[N-1:0]);
            default: expected = 1'b0;   // reserved modes expect constant 0
        endcase
    end

    // Next-state logic: sweep sequencing, comparison and result capture.
    always_comb begin
        state_d       = state_q;
        vec_d         = vec_q;
        settle_cnt_d  = settle_cnt_q;
        mode_d        = mode_q;
        err_d         = err_q;
        first_valid_d = first_valid_q;
        first_vec_d   = first_vec_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    mode_d        = mode;
                    err_d         = '0;
                    first_valid_d = 1'b0;
                    first_vec_d   = '0;
                    vec_d         = '0;
                    settle_cnt_d  = SETTLE_INIT;
                    state_d       = VEC_STATE;
                end
            end

            S_SETTLE: begin
                if (settle_cnt_q == 4'd0) begin
                    state_d = S_CHECK;
                end else begin
                    settle_cnt_d = settle_cnt_q - 1'b1;
                end
            end

            S_CHECK: begin
                if (dut_out != expected) begin
                    if (err_q != ERR_MAX) begin
                        err_d = err_q + 1'b1;
                    end
                    if (!first_valid_q) begin
                        first_valid_d = 1'b1;
                        first_vec_d   = vec_q[N-1:0];
                    end
                end
                if (vec_q == LAST_VEC) begin
                    state_d = S_DONE;   // dut_in keeps the last vector
                end else begin
                    vec_d        = vec_q + 1'b1;
                    settle_cnt_d = SETTLE_INIT;
                    state_d      = VEC_STATE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // State and result registers; reset abandons any sweep in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            vec_q         <= '0;
            settle_cnt_q  <= '0;
            mode_q        <= '0;
            err_q         <= '0;
            first_valid_q <= 1'b0;
            first_vec_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state_q       <= state_d;
            vec_q         <= vec_d;
            settle_cnt_q  <= settle_cnt_d;
            mode_q        <= mode_d;
            err_q         <= err_d;
            first_valid_q <= first_valid_d;
            first_vec_q   <= first_vec_d;
        end
    end

    assign dut_in          = vec_q[N-1:0];
    assign busy            = (state_q == S_SETTLE) || (state_q == S_CHECK);
    assign done            = (state_q == S_DONE);
    assign pass            = done && (err_q == '0);
    assign err_count       = err_q;
    assign first_err_valid = first_valid_q;
    assign first_err_vec   = first_vec_q;

endmodule
